// File: rtl/dmem_resp_if.sv
// Bus between the pipeline MEM stage and the data-memory response unit.
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both high. req_ready is high only while the unit is idle.
// A response is a single-cycle rsp_valid pulse with no backpressure.
// rsp_rdata and rsp_err are meaningful only while rsp_valid is high.
interface dmem_resp_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, stall, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, stall, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_resp.sv
// Fixed-latency data memory with an IDLE/BUSY/RESP sequencer.
// One request is in flight at a time. Misaligned accesses never touch the
// array and answer with rsp_err after the normal latency. Upper address
// bits are ignored, so addresses alias modulo 4*DEPTH bytes.
module dmem_resp #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    dmem_resp_if.slave bus,
    output logic [1:0] dbg_state
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic [3:0]      cnt_nxt;

    logic            we_q;
    logic            mis_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic            err_q;

    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic            enter_resp;
    logic            op_we;
    logic            op_mis;
    logic [AW-1:0]   op_idx;
    logic [31:0]     op_wdata;
    logic            unused_addr_hi;

    assign accept     = (state == IDLE) && bus.req_valid;
    assign enter_resp = (state_nxt == RESP);

    // With LATENCY=1 the array is touched on the acceptance edge itself, so
    // the operation comes straight from the bus; otherwise from the capture.
    assign op_we    = (state == IDLE) ? bus.req_we                 : we_q;
    assign op_mis   = (state == IDLE) ? (bus.req_addr[1:0] != 2'b00) : mis_q;
    assign op_idx   = (state == IDLE) ? bus.req_addr[AW+1:2]       : idx_q;
    assign op_wdata = (state == IDLE) ? bus.req_wdata              : wdata_q;

    assign unused_addr_hi = ^bus.req_addr[31:AW+2];

    assign bus.req_ready = (state == IDLE);
    assign bus.stall     = (state == BUSY) || accept;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign dbg_state     = state;

    // State and latency counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: IDLE accepts, BUSY counts down, RESP lasts one cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY > 1) begin
                        state_nxt = BUSY;
                        cnt_nxt   = 4'(LATENCY - 1);
                    end else begin
                        state_nxt = RESP;
                        cnt_nxt   = 4'd0;
                    end
                end
            end
            BUSY: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Capture the request fields at the acceptance edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            mis_q   <= (bus.req_addr[1:0] != 2'b00);
            idx_q   <= bus.req_addr[AW+1:2];
            wdata_q <= bus.req_wdata;
        end
    end

    // Response data/error registered on the edge entering RESP; data holds afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            rdata_q <= (op_we || op_mis) ? 32'd0 : mem[op_idx];
            err_q   <= op_mis;
        end else begin
            err_q   <= 1'b0;
        end
    end

    // Array write on the edge entering RESP; suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && op_we && !op_mis) begin
            mem[op_idx] <= op_wdata;
        end
    end
endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp at LATENCY 2, 1 and 3 (one instance each).
// Drivers push the expected response and its cycle into a queue at
// acceptance; a monitor pops and compares whenever any instance pulses
// rsp_valid. Requests are issued to one instance at a time.
module tb_dmem_resp;
    logic clk = 1'b0;
    logic r0 = 1'b1;
    logic r1 = 1'b1;
    logic r2 = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [32:0] exp_q[$];
    int          exp_cyc_q[$];
    int          exp_id_q[$];

    logic [1:0] dbg0, dbg1, dbg2;

    dmem_resp_if if0 ();
    dmem_resp_if if1 ();
    dmem_resp_if if2 ();

    dmem_resp #(.DEPTH(64), .LATENCY(2)) dut0 (.clk(clk), .reset(r0), .bus(if0), .dbg_state(dbg0));
    dmem_resp #(.DEPTH(64), .LATENCY(1)) dut1 (.clk(clk), .reset(r1), .bus(if1), .dbg_state(dbg1));
    dmem_resp #(.DEPTH(64), .LATENCY(3)) dut2 (.clk(clk), .reset(r2), .bus(if2), .dbg_state(dbg2));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int id, input logic v, input logic e, input logic [31:0] d);
        logic [32:0] ed;
        int          ec;
        int          ei;
        if (v === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rsp: got response on dut%0d data %h required none", id, {e, d});
            end else begin
                ed = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                ei = exp_id_q.pop_front();
                chk("rsp_id", 33'(id), 33'(ei));
                chk("rsp_cycle", 33'(cyc), 33'(ec));
                chk("rsp_err_data", {e, d}, ed);
            end
        end else begin
            chk("err_outside_resp", {32'd0, e}, 33'd0);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        mon(0, if0.rsp_valid, if0.rsp_err, if0.rsp_rdata);
        mon(1, if1.rsp_valid, if1.rsp_err, if1.rsp_rdata);
        mon(2, if2.rsp_valid, if2.rsp_err, if2.rsp_rdata);
    end

    // ---------------- driver tasks ----------------
    // Presents a request, expects acceptance in its first cycle, pushes the
    // expected response, and checks stall/req_ready until RESP has passed.
    task automatic do_req(input virtual dmem_resp_if vif, input int id, input int lat,
                          input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rdata, input logic hold);
        int   start;
        int   t_acc;
        logic got;
        @(posedge clk);
        #1;
        vif.req_valid = 1'b1;
        vif.req_we    = we;
        vif.req_addr  = addr;
        vif.req_wdata = wdata;
        start = cyc;
        t_acc = 0;
        got   = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (vif.req_ready === 1'b1) begin
                got   = 1'b1;
                t_acc = cyc;
            end
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got no acceptance on dut%0d required acceptance", id);
            vif.req_valid = 1'b0;
        end else begin
            chk("accept_cycle", 33'(t_acc), 33'(start));
            chk("stall_on_accept", {32'd0, vif.stall}, 33'd1);
            exp_q.push_back({exp_err, exp_rdata});
            exp_cyc_q.push_back(t_acc + lat);
            exp_id_q.push_back(id);
            for (int k = 1; k <= lat; k++) begin
                @(posedge clk);
                #1;
                if (!hold) vif.req_valid = 1'b0;
                @(negedge clk);
                chk("ready_low_after_accept", {32'd0, vif.req_ready}, 33'd0);
                if (k < lat) chk("stall_busy", {32'd0, vif.stall}, 33'd1);
                else         chk("stall_resp", {32'd0, vif.stall}, 33'd0);
            end
        end
    endtask

    // Write to 0x20 on dut0 (LATENCY=2) aborted by reset during BUSY.
    task automatic abort_write();
        @(posedge clk);
        #1;
        if0.req_valid = 1'b1;
        if0.req_we    = 1'b1;
        if0.req_addr  = 32'h20;
        if0.req_wdata = 32'hAAAA5555;
        @(negedge clk);
        chk("abort_accept_ready", {32'd0, if0.req_ready}, 33'd1);
        @(posedge clk);
        #1;
        if0.req_valid = 1'b0;
        chk("abort_in_busy", {32'd0, if0.stall}, 33'd1);
        r0 = 1'b0;
        #1;
        chk("abort_ready", {32'd0, if0.req_ready}, 33'd1);
        chk("abort_rsp_valid", {32'd0, if0.rsp_valid}, 33'd0);
        chk("abort_rsp_rdata", {1'b0, if0.rsp_rdata}, 33'd0);
        chk("abort_rsp_err", {32'd0, if0.rsp_err}, 33'd0);
        chk("abort_stall_novalid", {32'd0, if0.stall}, 33'd0);
        if0.req_valid = 1'b1;
        #1;
        chk("abort_stall_valid", {32'd0, if0.stall}, 33'd1);
        if0.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        r0 = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        if0.req_valid = 1'b0; if0.req_we = 1'b0; if0.req_addr = 32'd0; if0.req_wdata = 32'd0;
        if1.req_valid = 1'b0; if1.req_we = 1'b0; if1.req_addr = 32'd0; if1.req_wdata = 32'd0;
        if2.req_valid = 1'b0; if2.req_we = 1'b0; if2.req_addr = 32'd0; if2.req_wdata = 32'd0;
        #1;
        r0 = 1'b0; r1 = 1'b0; r2 = 1'b0;
        #2;
        chk("rst_ready0", {32'd0, if0.req_ready}, 33'd1);
        chk("rst_ready1", {32'd0, if1.req_ready}, 33'd1);
        chk("rst_ready2", {32'd0, if2.req_ready}, 33'd1);
        chk("rst_valid0", {32'd0, if0.rsp_valid}, 33'd0);
        chk("rst_rdata0", {1'b0, if0.rsp_rdata}, 33'd0);
        chk("rst_err0", {32'd0, if0.rsp_err}, 33'd0);
        chk("rst_stall0", {32'd0, if0.stall}, 33'd0);
        if0.req_valid = 1'b1;
        if2.req_valid = 1'b1;
        #1;
        chk("rst_stall_valid0", {32'd0, if0.stall}, 33'd1);
        chk("rst_stall_valid2", {32'd0, if2.stall}, 33'd1);
        if0.req_valid = 1'b0;
        if2.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;

        // LATENCY=2
        do_req(if0, 0, 2, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0);
        do_req(if0, 0, 2, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 1'b0);
        do_req(if0, 0, 2, 1'b0, 32'h13,  32'h0,        1'b1, 32'h0,        1'b0);
        do_req(if0, 0, 2, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 1'b0);
        do_req(if0, 0, 2, 1'b1, 32'h100, 32'h1234,     1'b0, 32'h0,        1'b0);
        do_req(if0, 0, 2, 1'b0, 32'h0,   32'h0,        1'b0, 32'h1234,     1'b0);
        do_req(if0, 0, 2, 1'b1, 32'h20,  32'h5A5A0001, 1'b0, 32'h0,        1'b0);
        do_req(if0, 0, 2, 1'b0, 32'h20,  32'h0,        1'b0, 32'h5A5A0001, 1'b0);
        abort_write();
        do_req(if0, 0, 2, 1'b0, 32'h20,  32'h0,        1'b0, 32'h5A5A0001, 1'b0);
        do_req(if0, 0, 2, 1'b1, 32'h22,  32'hFFFFFFFF, 1'b1, 32'h0,        1'b0);
        do_req(if0, 0, 2, 1'b0, 32'h20,  32'h0,        1'b0, 32'h5A5A0001, 1'b0);

        // LATENCY=1, including a read held valid through its response
        do_req(if1, 1, 1, 1'b1, 32'h40,  32'hCAFE0001, 1'b0, 32'h0,        1'b0);
        do_req(if1, 1, 1, 1'b0, 32'h40,  32'h0,        1'b0, 32'hCAFE0001, 1'b1);
        do_req(if1, 1, 1, 1'b1, 32'h44,  32'h00000077, 1'b0, 32'h0,        1'b0);
        do_req(if1, 1, 1, 1'b0, 32'h44,  32'h0,        1'b0, 32'h00000077, 1'b0);
        do_req(if1, 1, 1, 1'b1, 32'h41,  32'h12345678, 1'b1, 32'h0,        1'b0);
        do_req(if1, 1, 1, 1'b0, 32'h40,  32'h0,        1'b0, 32'hCAFE0001, 1'b0);

        // LATENCY=3, back-to-back write then read of the same word
        do_req(if2, 2, 3, 1'b1, 32'h8,   32'h00000001, 1'b0, 32'h0,        1'b0);
        do_req(if2, 2, 3, 1'b0, 32'h8,   32'h0,        1'b0, 32'h00000001, 1'b0);
        do_req(if2, 2, 3, 1'b0, 32'h9,   32'h0,        1'b1, 32'h0,        1'b0);
        do_req(if2, 2, 3, 1'b0, 32'h108, 32'h0,        1'b0, 32'h00000001, 1'b0);

        repeat (6) @(negedge clk);
        chk("queue_drained", 33'(exp_q.size()), 33'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DEPTH, default 64, SHALL set the number of 32-bit words in the backing array (power of 2, 4..1024).
REQ-002 Parameter LATENCY, default 2, SHALL set the cycles from request acceptance to response (legal range 1..15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  input  1  SHALL indicate a MEM-stage access request from the pipeline.
REQ-006 req_we  input  1  SHALL select write (1) or read (0).
REQ-007 req_addr  input  32  SHALL be the byte address (ALUOutM).
REQ-008 req_wdata  input  32  SHALL be the store data (WriteDataM).
REQ-009 req_ready  output  1  SHALL be high only in IDLE.
REQ-010 stall  output  1  SHALL request the pipeline to hold the F/D/E/M stages.
REQ-011 rsp_valid  output  1  SHALL mark a one-cycle response.
REQ-012 rsp_rdata  output  32  SHALL carry read data during rsp_valid.
REQ-013 rsp_err  output  1  SHALL flag a misaligned access during rsp_valid.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY, RESP.
REQ-015 A request SHALL be accepted on the rising edge ending a cycle with state IDLE and req_valid=1; req_we, word index and req_wdata are captured at that edge.
REQ-016 On acceptance, the next state SHALL be BUSY with counter=LATENCY-1 if LATENCY>1, else RESP.
REQ-017 In BUSY, the counter SHALL decrement each cycle; when the counter equals 1, the next state SHALL be RESP.
REQ-018 RESP SHALL last exactly one cycle and then return to IDLE, regardless of req_valid.
REQ-019 Acceptance in cycle T SHALL yield rsp_valid=1 in cycle T+LATENCY only.
REQ-020 stall SHALL be combinational: 1 in BUSY, 1 in IDLE when req_valid=1, and 0 in RESP and in idle-without-request.
REQ-021 req_valid SHALL be ignored in BUSY and RESP, so a held request is not re-accepted in RESP.
REQ-022 Word index SHALL be req_addr[log2(DEPTH)+1:2]; upper address bits SHALL be ignored, so addresses alias modulo 4*DEPTH.
REQ-023 For an aligned write, the array word SHALL be updated on the edge entering RESP; in RESP, rsp_rdata=0 and rsp_err=0.
REQ-024 For an aligned read, rsp_rdata SHALL be registered from the array on the edge entering RESP.
REQ-025 If req_addr[1:0]!=0, there SHALL be no array access; in RESP, rsp_err=1 and rsp_rdata=0, with unchanged latency.
REQ-026 Outside RESP, rsp_valid=0 and rsp_err=0; rsp_rdata SHALL hold its last value.
REQ-027 A read to the same word as the immediately preceding write SHALL return the new data.

Reset
REQ-028 While reset=0, state SHALL be IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1, and stall=req_valid, taking effect asynchronously.
REQ-029 Reset asserted in BUSY SHALL abort the access: no array write, and no response after release.
REQ-030 Array contents SHALL NOT be reset; reads of never-written words return undefined data.

Verification
REQ-031 LATENCY=2: write 0xDEADBEEF to addr 0x10 accepted in cycle T -> stall=1 in T,T+1; rsp_valid=1, rsp_rdata=0 in T+2; then read 0x10 -> rsp_rdata=0xDEADBEEF two cycles after its acceptance.
REQ-032 LATENCY=1: read held valid continuously -> accepted once; rsp_valid=1 in T+1, stall=0 in T+1, IDLE in T+2; a second request is accepted at T+2.
REQ-033 Misaligned read addr 0x13 -> rsp_err=1, rsp_rdata=0 at T+LATENCY; array unchanged, verified by a read of 0x10.
REQ-034 DEPTH=64: write 0x1234 to addr 0x100 -> read of addr 0x0 returns 0x1234 (aliasing).
REQ-035 Write 0xAAAA5555 to addr 0x20 and assert reset in the BUSY cycle -> outputs match REQ-028 immediately, no rsp_valid after release, and a later read of 0x20 returns prior contents.
REQ-036 Back-to-back write 0x1 then read to addr 0x8 with LATENCY=3 -> responses in T+3 and T+7; the read returns 0x1.
